// File: rtl/datapath_pkg.sv
// Shared definitions for the datapath sequencing controller: instruction
// field layout, opcode/op encodings, datapath control codes and FSM states.
package datapath_pkg;

  // Opcode field values
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  // op field values under OPC_MOV
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;

  // op field values under OPC_ALU (these double as the ALUop code)
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_CMP = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_MVN = 2'b11;

  // ALU operation codes
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

  // Shifter codes
  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL1 = 2'b01;
  localparam logic [1:0] SH_LSR1 = 2'b10;
  localparam logic [1:0] SH_ASR1 = 2'b11;

  // Instruction field bit positions
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 13;
  localparam int OP_HI  = 12;
  localparam int OP_LO  = 11;
  localparam int RN_HI  = 10;
  localparam int RN_LO  = 8;
  localparam int RD_HI  = 7;
  localparam int RD_LO  = 5;
  localparam int SH_HI  = 4;
  localparam int SH_LO  = 3;
  localparam int RM_HI  = 2;
  localparam int RM_LO  = 0;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  // Controller FSM states
  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_IMM,
    S_GET_A,
    S_GET_B,
    S_CALC,
    S_WR_REG,
    S_DONE
  } ctrl_state_t;

  // Decoded instruction class; CLS_ILLEGAL covers every unlisted opcode/op pair
  typedef enum logic [2:0] {
    CLS_ILLEGAL,
    CLS_MOV_IMM,
    CLS_MOV_REG,
    CLS_ADD,
    CLS_CMP,
    CLS_AND,
    CLS_MVN
  } instr_class_t;

  // Sign-extend the 8-bit immediate to datapath width
  function automatic logic [15:0] sign_extend8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/datapath_ctrl_if.sv
// Instruction handshake and datapath control bundle between instruction
// fetch (master) and the sequencing controller (slave).
interface datapath_ctrl_if;

  logic        start;
  logic [15:0] instr;
  logic        ready;
  logic        done;
  logic        err;
  logic [15:0] datapath_in;
  logic        write;
  logic        vsel;
  logic        loada;
  logic        loadb;
  logic        asel;
  logic        bsel;
  logic        loadc;
  logic        loads;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic [1:0]  ALUop;
  logic [1:0]  shift;

  modport master (
    output start, instr,
    input  ready, done, err, datapath_in,
    input  write, vsel, loada, loadb, asel, bsel, loadc, loads,
    input  readnum, writenum, ALUop, shift
  );

  modport slave (
    input  start, instr,
    output ready, done, err, datapath_in,
    output write, vsel, loada, loadb, asel, bsel, loadc, loads,
    output readnum, writenum, ALUop, shift
  );

endinterface

// File: rtl/instr_decoder.sv
// Combinational instruction decoder. Splits the latched instruction into its
// fields and sign-extends imm8; classifies both the latched word (drives the
// per-state strobes) and the incoming bus word (chooses the first state on
// accept, before the latch has been loaded).
module instr_decoder
  import datapath_pkg::*;
(
  input  logic [15:0]  cur_instr,
  input  logic [15:0]  new_instr,
  output instr_class_t cur_class,
  output instr_class_t new_class,
  output logic [1:0]   op,
  output logic [2:0]   rn,
  output logic [2:0]   rd,
  output logic [2:0]   rm,
  output logic [1:0]   sh,
  output logic [15:0]  imm_sx
);

  function automatic instr_class_t classify(input logic [15:0] w);
    logic [2:0] opc;
    logic [1:0] o;
    instr_class_t cls;
    opc = w[OPC_HI:OPC_LO];
    o   = w[OP_HI:OP_LO];
    cls = CLS_ILLEGAL;
    if (opc == OPC_MOV) begin
      if (o == OP_MOV_IMM)      cls = CLS_MOV_IMM;
      else if (o == OP_MOV_REG) cls = CLS_MOV_REG;
    end else if (opc == OPC_ALU) begin
      case (o)
        OP_ADD:  cls = CLS_ADD;
        OP_CMP:  cls = CLS_CMP;
        OP_AND:  cls = CLS_AND;
        default: cls = CLS_MVN;
      endcase
    end
    return cls;
  endfunction

  assign cur_class = classify(cur_instr);
  assign new_class = classify(new_instr);

  assign op     = cur_instr[OP_HI:OP_LO];
  assign rn     = cur_instr[RN_HI:RN_LO];
  assign rd     = cur_instr[RD_HI:RD_LO];
  assign rm     = cur_instr[RM_HI:RM_LO];
  assign sh     = cur_instr[SH_HI:SH_LO];
  assign imm_sx = sign_extend8(cur_instr[IMM_HI:IMM_LO]);

endmodule

// File: rtl/datapath_ctrl.sv
// Sequencing controller for the register-file/ALU datapath. Accepts one
// instruction per start/done handshake, latches it, and steps through a
// Moore FSM whose state plus the latched word fully determine every strobe.
module datapath_ctrl
  import datapath_pkg::*;
(
  input logic             clk,
  input logic             reset_n,
  datapath_ctrl_if.slave  bus
);

  ctrl_state_t  state;
  ctrl_state_t  next_state;
  logic [15:0]  instr_q;

  instr_class_t cur_class;
  instr_class_t new_class;
  logic [1:0]   op;
  logic [2:0]   rn;
  logic [2:0]   rd;
  logic [2:0]   rm;
  logic [1:0]   sh;
  logic [15:0]  imm_sx;

  logic         ready_d;
  logic         done_d;
  logic         err_d;
  logic         write_d;
  logic         vsel_d;
  logic         loada_d;
  logic         loadb_d;
  logic         asel_d;
  logic         loadc_d;
  logic         loads_d;
  logic [2:0]   readnum_d;
  logic [2:0]   writenum_d;

  instr_decoder u_decoder (
    .cur_instr (instr_q),
    .new_instr (bus.instr),
    .cur_class (cur_class),
    .new_class (new_class),
    .op        (op),
    .rn        (rn),
    .rd        (rd),
    .rm        (rm),
    .sh        (sh),
    .imm_sx    (imm_sx)
  );

  // State register; reset drops straight back to IDLE from any state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  // Instruction latch, loaded only on the edge that accepts start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          instr_q <= '0;
    else if (state == S_IDLE && bus.start) instr_q <= bus.instr;
  end

  // Next-state selection; the first state depends on the incoming word
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          case (new_class)
            CLS_MOV_IMM:                next_state = S_WR_IMM;
            CLS_ADD, CLS_CMP, CLS_AND:  next_state = S_GET_A;
            CLS_MOV_REG, CLS_MVN:       next_state = S_GET_B;
            default:                    next_state = S_DONE;
          endcase
        end
      end
      S_WR_IMM: next_state = S_DONE;
      S_GET_A:  next_state = S_GET_B;
      S_GET_B:  next_state = S_CALC;
      S_CALC:   next_state = (cur_class == CLS_CMP) ? S_DONE : S_WR_REG;
      S_WR_REG: next_state = S_DONE;
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Moore strobe decode from state and the latched instruction
  always_comb begin
    ready_d    = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    write_d    = 1'b0;
    vsel_d     = 1'b0;
    loada_d    = 1'b0;
    loadb_d    = 1'b0;
    asel_d     = 1'b0;
    loadc_d    = 1'b0;
    loads_d    = 1'b0;
    readnum_d  = 3'b000;
    writenum_d = 3'b000;
    case (state)
      S_IDLE: ready_d = 1'b1;
      S_WR_IMM: begin
        write_d    = 1'b1;
        vsel_d     = 1'b1;
        writenum_d = rn;
      end
      S_GET_A: begin
        loada_d   = 1'b1;
        readnum_d = rn;
      end
      S_GET_B: begin
        loadb_d   = 1'b1;
        readnum_d = rm;
      end
      S_CALC: begin
        asel_d = (cur_class == CLS_MOV_REG);
        if (cur_class == CLS_CMP) loads_d = 1'b1;
        else                      loadc_d = 1'b1;
      end
      S_WR_REG: begin
        write_d    = 1'b1;
        writenum_d = rd;
      end
      S_DONE: begin
        done_d = 1'b1;
        err_d  = (cur_class == CLS_ILLEGAL);
      end
      default: ready_d = 1'b0;
    endcase
  end

  assign bus.ready       = ready_d;
  assign bus.done        = done_d;
  assign bus.err         = err_d;
  assign bus.write       = write_d;
  assign bus.vsel        = vsel_d;
  assign bus.loada       = loada_d;
  assign bus.loadb       = loadb_d;
  assign bus.asel        = asel_d;
  assign bus.bsel        = 1'b0;
  assign bus.loadc       = loadc_d;
  assign bus.loads       = loads_d;
  assign bus.readnum     = readnum_d;
  assign bus.writenum    = writenum_d;
  // MOV reg reuses the adder with A forced to zero, so its op bits are overridden
  assign bus.ALUop       = (cur_class == CLS_MOV_REG) ? ALU_ADD : op;
  assign bus.shift       = sh;
  assign bus.datapath_in = imm_sx;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Bench for datapath_ctrl: a behavioural register-file/ALU datapath follows
// the controller strobes; a scoreboard holds the expected done cycle and err
// of each issued instruction and a monitor retires them as done appears.
module tb_datapath_ctrl;
  import datapath_pkg::*;

  typedef struct {
    int    done_cyc;
    logic  err;
    string name;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t mon_e;

  logic [15:0] regs [8] = '{default: 16'h0000};
  logic [15:0] reg_a = 16'h0;
  logic [15:0] reg_b = 16'h0;
  logic [15:0] reg_c = 16'h0;
  logic        z_flag = 1'b0;
  logic [15:0] ain, bin, alu_out;

  int n_loada = 0, n_loadb = 0, n_loadc = 0, n_loads = 0, n_write = 0;
  int c_loada = 0, c_loadb = 0, c_loadc = 0, c_write = 0;

  datapath_ctrl_if bus();

  datapath_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Cycle counter used to timestamp accepts and done pulses
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] shift_f(input logic [15:0] v, input logic [1:0] s);
    case (s)
      SH_LSL1: return {v[14:0], 1'b0};
      SH_LSR1: return {1'b0, v[15:1]};
      SH_ASR1: return {v[15], v[15:1]};
      default: return v;
    endcase
  endfunction

  // Behavioural ALU of the datapath
  always_comb begin
    ain = bus.asel ? 16'h0000 : reg_a;
    bin = bus.bsel ? {11'h000, bus.datapath_in[4:0]} : shift_f(reg_b, bus.shift);
    case (bus.ALUop)
      ALU_ADD: alu_out = ain + bin;
      ALU_SUB: alu_out = ain - bin;
      ALU_AND: alu_out = ain & bin;
      default: alu_out = ~bin;
    endcase
  end

  // Behavioural register file and pipeline registers driven by the strobes
  always @(posedge clk) begin
    if (bus.write) regs[bus.writenum] <= bus.vsel ? bus.datapath_in : reg_c;
    if (bus.loada) reg_a <= regs[bus.readnum];
    if (bus.loadb) reg_b <= regs[bus.readnum];
    if (bus.loadc) reg_c <= alu_out;
    if (bus.loads) z_flag <= (alu_out == 16'h0000);
  end

  // Strobe activity counters and the cycle each strobe was last seen
  always @(negedge clk) begin
    if (bus.loada) begin n_loada <= n_loada + 1; c_loada <= cyc; end
    if (bus.loadb) begin n_loadb <= n_loadb + 1; c_loadb <= cyc; end
    if (bus.loadc) begin n_loadc <= n_loadc + 1; c_loadc <= cyc; end
    if (bus.loads) n_loads <= n_loads + 1;
    if (bus.write) begin n_write <= n_write + 1; c_write <= cyc; end
  end

  // Monitor: every done pulse retires the oldest expected instruction
  always @(negedge clk) begin
    if (reset_n && bus.done) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_done: done=1 at cyc %0d, required no outstanding instruction", cyc);
      end else begin
        mon_e = sb.pop_front();
        if (cyc != mon_e.done_cyc || bus.err !== mon_e.err)
        begin
          failures++;
          $display("[TB] FAIL %s: done at cyc %0d err=%0b, required cyc %0d err=%0b",
                   mon_e.name, cyc, bus.err, mon_e.done_cyc, mon_e.err);
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("[TB] FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  task automatic push_expect(input int done_cyc, input logic err, input string name);
    exp_t e;
    e.done_cyc = done_cyc;
    e.err      = err;
    e.name     = name;
    sb.push_back(e);
  endtask

  task automatic wait_ready(input string name);
    int w = 0;
    while (!bus.ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!bus.ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_ready_timeout: ready=0 after %0d cycles, required 1", name, w);
    end
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while (sb.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_done_timeout: %0d instructions outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  // Issue one instruction at a negedge; optionally pulse start mid-instruction
  task automatic apply_stimulus(input logic [15:0] word, input int latency,
                                input logic exp_err, input string name, input bit poke);
    wait_ready(name);
    bus.start = 1'b1;
    bus.instr = word;
    push_expect(cyc + latency, exp_err, name);
    @(negedge clk);
    bus.start = 1'b0;
    bus.instr = 16'hE7E7;
    if (poke) begin
      bus.start = 1'b1;
      bus.instr = 16'h0000;
      @(negedge clk);
      bus.start = 1'b0;
      bus.instr = 16'hE7E7;
    end
    wait_drain(name);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    int s_la, s_lb, s_lc, s_ls, s_wr;
    bus.start = 1'b0;
    bus.instr = 16'h0000;

    #1;
    check_output("reset_ready", bus.ready, 1);
    check_output("reset_done_err", {bus.done, bus.err}, 0);
    check_output("reset_strobes", {bus.write, bus.vsel, bus.loada, bus.loadb,
                                   bus.asel, bus.bsel, bus.loadc, bus.loads}, 0);
    check_output("reset_addr_ctrl", {bus.readnum, bus.writenum, bus.ALUop, bus.shift}, 0);
    check_output("reset_datapath_in", bus.datapath_in, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    apply_stimulus(16'hD007, 2, 1'b0, "mov_r0_7", 1'b0);
    check_output("r0_eq_7", regs[0], 16'h0007);
    apply_stimulus(16'hD102, 2, 1'b0, "mov_r1_2", 1'b0);
    check_output("r1_eq_2", regs[1], 16'h0002);

    s_la = n_loada; s_lb = n_loadb; s_lc = n_loadc; s_wr = n_write;
    apply_stimulus(16'hA148, 5, 1'b0, "add_r2_lsl", 1'b1);
    check_output("r2_eq_16", regs[2], 16'h0010);
    check_output("add_strobe_counts",
                 {8'(n_loada - s_la), 8'(n_loadb - s_lb), 8'(n_loadc - s_lc), 8'(n_write - s_wr)},
                 32'h01010101);
    check_output("add_strobe_order",
                 {31'h0, (c_loada < c_loadb) && (c_loadb < c_loadc) && (c_loadc < c_write)}, 1);

    apply_stimulus(16'hD3FF, 2, 1'b0, "mov_r3_neg1", 1'b0);
    check_output("r3_eq_ffff", regs[3], 16'hFFFF);
    apply_stimulus(16'hD401, 2, 1'b0, "mov_r4_1", 1'b0);
    apply_stimulus(16'hB883, 4, 1'b0, "mvn_r4_r3", 1'b0);
    check_output("r4_eq_0", regs[4], 16'h0000);

    s_wr = n_write;
    apply_stimulus(16'hA800, 4, 1'b0, "cmp_r0_r0", 1'b0);
    check_output("cmp_z_flag", z_flag, 1);
    check_output("cmp_no_write", n_write - s_wr, 0);
    check_output("cmp_regs_kept", {regs[0], regs[2]}, {16'h0007, 16'h0010});

    apply_stimulus(16'hC0B1, 4, 1'b0, "mov_r5_r1_lsr", 1'b0);
    check_output("r5_eq_1", regs[5], 16'h0001);
    apply_stimulus(16'hB0C1, 5, 1'b0, "and_r6", 1'b0);
    check_output("r6_eq_2", regs[6], 16'h0002);
    apply_stimulus(16'hA3FB, 5, 1'b0, "add_r7_asr", 1'b0);
    check_output("r7_eq_fffe", regs[7], 16'hFFFE);

    s_la = n_loada; s_lb = n_loadb; s_lc = n_loadc; s_ls = n_loads; s_wr = n_write;
    apply_stimulus(16'h0000, 1, 1'b1, "illegal_opc000", 1'b0);
    apply_stimulus(16'hC800, 1, 1'b1, "illegal_mov_op01", 1'b0);
    check_output("illegal_no_strobes",
                 (n_loada - s_la) + (n_loadb - s_lb) + (n_loadc - s_lc) + (n_loads - s_ls) + (n_write - s_wr), 0);

    // start held high across two MOVs: second is taken on the edge after done
    wait_ready("b2b");
    k = cyc;
    bus.start = 1'b1;
    bus.instr = 16'hD605;
    push_expect(k + 2, 1'b0, "b2b_mov_r6");
    push_expect(k + 5, 1'b0, "b2b_mov_r7");
    @(negedge clk);
    bus.instr = 16'hD709;
    repeat (3) @(negedge clk);
    bus.start = 1'b0;
    bus.instr = 16'hE7E7;
    wait_drain("b2b");
    check_output("b2b_r6_r7", {regs[6], regs[7]}, {16'h0005, 16'h0009});

    // Reset during GET_B of an AND that would have overwritten R2
    wait_ready("abort");
    bus.start = 1'b1;
    bus.instr = 16'hB150;
    @(negedge clk);
    bus.start = 1'b0;
    bus.instr = 16'hE7E7;
    @(negedge clk);
    check_output("abort_in_getb", {bus.loadb, bus.ALUop, bus.shift}, 5'b1_10_10);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("abort_ready", bus.ready, 1);
    check_output("abort_outputs_cleared",
                 {bus.loadb, bus.loada, bus.loadc, bus.write, bus.done, bus.err,
                  bus.readnum, bus.writenum, bus.ALUop, bus.shift}, 0);
    check_output("abort_datapath_in", bus.datapath_in, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    check_output("abort_r2_kept", regs[2], 16'h0010);
    apply_stimulus(16'hD503, 2, 1'b0, "mov_r5_after_reset", 1'b0);
    check_output("r5_eq_3", regs[5], 16'h0003);

    repeat (3) @(negedge clk);
    check_output("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
